// File: rtl/mux_scan_pkg.sv
// Shared types for the scanning N:1 multiplexer: mode encodings, FSM states
// and the state decode used by the top-level controller.
package mux_scan_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAN  = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    // The state is a pure function of en/mode each cycle; history lives in the counters.
    function automatic state_t decode_state(input logic en, input logic mode);
        if (!en) return ST_IDLE;
        return (mode == MODE_SCAN) ? ST_SCAN : ST_MAN;
    endfunction

endpackage

// File: rtl/mux_nx1.sv
// Combinational N:1 word selector over a flat bus; an index outside
// 0..N_CH-1 falls back to channel 0.
module mux_nx1 #(
    parameter int N_CH = 4,
    parameter int DW   = 8,
    localparam int SW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH*DW-1:0] data_in,
    input  logic [SW-1:0]      sel,
    output logic [DW-1:0]      data_out
);

    always_comb begin
        data_out = data_in[DW-1:0];
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SW'(k)) data_out = data_in[k*DW +: DW];
        end
    end

endmodule

// File: rtl/mux_scan_nx1.sv
// N:1 channel multiplexer with registered output, offering a manual select
// mode and an auto-scan mode with a programmable per-channel dwell.
module mux_scan_nx1
    import mux_scan_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int DW      = 8,
    parameter int DWELL_W = 8,
    localparam int SW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [SW-1:0]      sel_in,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [N_CH*DW-1:0] data_in,
    output logic [DW-1:0]      data_out,
    output logic [SW-1:0]      ch_out,
    output logic               valid,
    output logic               wrap
);

    localparam logic [SW:0]   NCH_EXT = (SW+1)'(N_CH);
    localparam logic [SW-1:0] LAST_CH = SW'(N_CH - 1);

    state_t             state, state_nxt;
    logic [SW-1:0]      idx, idx_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic [DWELL_W-1:0] dwell_q, dwell_nxt;
    logic               wrap_pend, wrap_pend_nxt;
    logic [DW-1:0]      data_nxt;
    logic [SW-1:0]      ch_nxt;
    logic               valid_nxt, wrap_nxt;

    logic               restart;
    logic [SW-1:0]      man_ch, scan_idx, mux_sel;
    logic [DWELL_W-1:0] scan_cnt, slot_len;
    logic               slot_start;
    logic [DW-1:0]      mux_word;

    // Coming straight out of MAN the scan always begins at channel 0, cycle 0.
    assign state_nxt  = decode_state(en, mode);
    assign restart    = (state == ST_MAN);
    assign scan_idx   = restart ? '0 : idx;
    assign scan_cnt   = restart ? '0 : cnt;
    assign slot_start = (scan_cnt == '0);
    assign slot_len   = slot_start ? dwell : dwell_q;
    assign man_ch     = ({1'b0, sel_in} < NCH_EXT) ? sel_in : '0;
    assign mux_sel    = (state_nxt == ST_MAN) ? man_ch : scan_idx;

    mux_nx1 #(
        .N_CH (N_CH),
        .DW   (DW)
    ) u_mux (
        .data_in  (data_in),
        .sel      (mux_sel),
        .data_out (mux_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            cnt       <= '0;
            dwell_q   <= '0;
            wrap_pend <= 1'b0;
            data_out  <= '0;
            ch_out    <= '0;
            valid     <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            dwell_q   <= dwell_nxt;
            wrap_pend <= wrap_pend_nxt;
            data_out  <= data_nxt;
            ch_out    <= ch_nxt;
            valid     <= valid_nxt;
            wrap      <= wrap_nxt;
        end
    end

    // IDLE holds everything but drops the strobes; wrap_pend bridges the roll
    // from the last channel to the slot-start cycle of channel 0.
    always_comb begin
        idx_nxt       = idx;
        cnt_nxt       = cnt;
        dwell_nxt     = dwell_q;
        wrap_pend_nxt = wrap_pend;
        data_nxt      = data_out;
        ch_nxt        = ch_out;
        valid_nxt     = 1'b0;
        wrap_nxt      = 1'b0;
        case (state_nxt)
            ST_MAN: begin
                data_nxt      = mux_word;
                ch_nxt        = man_ch;
                valid_nxt     = 1'b1;
                idx_nxt       = '0;
                cnt_nxt       = '0;
                wrap_pend_nxt = 1'b0;
            end
            ST_SCAN: begin
                data_nxt  = mux_word;
                ch_nxt    = scan_idx;
                valid_nxt = slot_start;
                wrap_nxt  = slot_start && wrap_pend;
                if (slot_start) begin
                    dwell_nxt     = dwell;
                    wrap_pend_nxt = 1'b0;
                end
                if (scan_cnt == slot_len) begin
                    cnt_nxt = '0;
                    if (scan_idx == LAST_CH) begin
                        idx_nxt       = '0;
                        wrap_pend_nxt = 1'b1;
                    end else begin
                        idx_nxt = scan_idx + SW'(1);
                    end
                end else begin
                    cnt_nxt = scan_cnt + DWELL_W'(1);
                    idx_nxt = scan_idx;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Directed self-checking bench for mux_scan_nx1: a 4x8 instance for manual,
// scan, dwell and pause behaviour plus a 5x4 instance for non-power-of-two sizing.
module tb_mux_scan_nx1;

    logic clk = 1'b0;
    logic rst;

    logic        en, mode;
    logic [1:0]  sel_in;
    logic [7:0]  dwell;
    logic [31:0] data_in;
    logic [7:0]  data_out;
    logic [1:0]  ch_out;
    logic        valid, wrap;

    logic        en5, mode5;
    logic [2:0]  sel5;
    logic [7:0]  dwell5;
    logic [19:0] data5;
    logic [3:0]  dout5;
    logic [2:0]  ch5;
    logic        valid5, wrap5;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    mux_scan_nx1 #(.N_CH(4), .DW(8), .DWELL_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in),
        .dwell(dwell), .data_in(data_in), .data_out(data_out),
        .ch_out(ch_out), .valid(valid), .wrap(wrap)
    );

    mux_scan_nx1 #(.N_CH(5), .DW(4), .DWELL_W(8)) dut5 (
        .clk(clk), .rst(rst), .en(en5), .mode(mode5), .sel_in(sel5),
        .dwell(dwell5), .data_in(data5), .data_out(dout5),
        .ch_out(ch5), .valid(valid5), .wrap(wrap5)
    );

    // Inputs set before tick take effect at the edge; outputs are read 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        en = 1'b1; mode = 1'b0; sel_in = 2'd2; data_in = 32'hDDCC_BBAA;
        tick();
        #2 rst = 1'b1;
        #1;
        vec_cnt++;
        if ({data_out, ch_out, valid, wrap} !== 12'h000) begin
            err_cnt++;
            $display("[TB] FAIL reset_async: got %h want 000", {data_out, ch_out, valid, wrap});
        end
        #1 en = 1'b0; rst = 1'b0;
        tick();
        vec_cnt++;
        if ({data_out, ch_out, valid, wrap} !== 12'h000) begin
            err_cnt++;
            $display("[TB] FAIL reset_idle: got %h want 000", {data_out, ch_out, valid, wrap});
        end
    endtask

    task automatic test_manual();
        logic [1:0]  sweep [4] = '{2'd2, 2'd0, 2'd1, 2'd3};
        logic [11:0] exp;
        en = 1'b1; mode = 1'b0; data_in = 32'hDDCC_BBAA;
        for (int i = 0; i < 4; i++) begin
            sel_in = sweep[i];
            tick();
            exp = {8'hAA + 8'(sweep[i]) * 8'h11, sweep[i], 1'b1, 1'b0};
            vec_cnt++;
            if ({data_out, ch_out, valid, wrap} !== exp) begin
                err_cnt++;
                $display("[TB] FAIL manual sel=%0d: got %h want %h", sweep[i],
                         {data_out, ch_out, valid, wrap}, exp);
            end
        end
    endtask

    task automatic test_scan_dwell0();
        logic [1:0]  ch;
        logic [11:0] exp;
        mode = 1'b1; dwell = 8'd0;
        for (int i = 0; i < 12; i++) begin
            tick();
            ch  = 2'(i % 4);
            exp = {8'hAA + 8'(ch) * 8'h11, ch, 1'b1, (ch == 2'd0) && (i > 0)};
            vec_cnt++;
            if ({data_out, ch_out, valid, wrap} !== exp) begin
                err_cnt++;
                $display("[TB] FAIL scan0[%0d]: got %h want %h", i,
                         {data_out, ch_out, valid, wrap}, exp);
            end
        end
    endtask

    task automatic test_scan_dwell2();
        logic [1:0]  exp_ch [10] = '{0, 0, 0, 1, 1, 1, 2, 3, 0, 1};
        logic        exp_v  [10] = '{1, 0, 0, 1, 0, 0, 1, 1, 1, 1};
        logic [11:0] exp;
        mode = 1'b0;
        tick();
        mode = 1'b1; dwell = 8'd2;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) dwell = 8'd0;
            tick();
            exp = {8'hAA + 8'(exp_ch[i]) * 8'h11, exp_ch[i], exp_v[i], i == 8};
            vec_cnt++;
            if ({data_out, ch_out, valid, wrap} !== exp) begin
                err_cnt++;
                $display("[TB] FAIL scan2[%0d]: got %h want %h", i,
                         {data_out, ch_out, valid, wrap}, exp);
            end
        end
    endtask

    task automatic test_pause();
        logic [1:0]  ch;
        logic [11:0] exp;
        mode = 1'b0;
        tick();
        mode = 1'b1; dwell = 8'd2;
        for (int i = 0; i < 8; i++) begin
            tick();
            ch  = 2'(i / 3);
            exp = {8'hAA + 8'(ch) * 8'h11, ch, (i % 3) == 0, 1'b0};
            vec_cnt++;
            if ({data_out, ch_out, valid, wrap} !== exp) begin
                err_cnt++;
                $display("[TB] FAIL pause_pre[%0d]: got %h want %h", i,
                         {data_out, ch_out, valid, wrap}, exp);
            end
        end
        en = 1'b0; data_in = 32'h1122_3344;
        for (int i = 0; i < 5; i++) begin
            tick();
            vec_cnt++;
            if ({data_out, ch_out, valid, wrap} !== {8'hCC, 2'd2, 1'b0, 1'b0}) begin
                err_cnt++;
                $display("[TB] FAIL pause_hold[%0d]: got %h want %h", i,
                         {data_out, ch_out, valid, wrap}, {8'hCC, 2'd2, 2'b00});
            end
        end
        en = 1'b1;
        tick();
        vec_cnt++;
        if ({data_out, ch_out, valid, wrap} !== {8'h22, 2'd2, 1'b0, 1'b0}) begin
            err_cnt++;
            $display("[TB] FAIL pause_resume: got %h want %h",
                     {data_out, ch_out, valid, wrap}, {8'h22, 2'd2, 2'b00});
        end
        tick();
        vec_cnt++;
        if ({data_out, ch_out, valid, wrap} !== {8'h11, 2'd3, 1'b1, 1'b0}) begin
            err_cnt++;
            $display("[TB] FAIL pause_next: got %h want %h",
                     {data_out, ch_out, valid, wrap}, {8'h11, 2'd3, 2'b10});
        end
    endtask

    task automatic test_nch5();
        logic [2:0] ch;
        logic [8:0] exp;
        en5 = 1'b1; mode5 = 1'b0; data5 = 20'h54321; sel5 = 3'd6;
        tick();
        vec_cnt++;
        if ({dout5, ch5, valid5, wrap5} !== {4'h1, 3'd0, 1'b1, 1'b0}) begin
            err_cnt++;
            $display("[TB] FAIL n5_oob: got %h want %h", {dout5, ch5, valid5, wrap5},
                     {4'h1, 3'd0, 2'b10});
        end
        sel5 = 3'd4;
        tick();
        vec_cnt++;
        if ({dout5, ch5, valid5, wrap5} !== {4'h5, 3'd4, 1'b1, 1'b0}) begin
            err_cnt++;
            $display("[TB] FAIL n5_sel4: got %h want %h", {dout5, ch5, valid5, wrap5},
                     {4'h5, 3'd4, 2'b10});
        end
        mode5 = 1'b1; dwell5 = 8'd0;
        for (int i = 0; i < 7; i++) begin
            tick();
            ch  = 3'(i % 5);
            exp = {4'(ch) + 4'h1, ch, 1'b1, i == 5};
            vec_cnt++;
            if ({dout5, ch5, valid5, wrap5} !== exp) begin
                err_cnt++;
                $display("[TB] FAIL n5_scan[%0d]: got %h want %h", i,
                         {dout5, ch5, valid5, wrap5}, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0; mode = 1'b0; sel_in = '0; dwell = '0; data_in = '0;
        en5 = 1'b0; mode5 = 1'b0; sel5 = '0; dwell5 = '0; data5 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        $display("[TB] starting directed tests");
        test_reset();
        test_manual();
        test_scan_dwell0();
        test_scan_dwell2();
        test_pause();
        test_nch5();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
